spi_master_tx: RTL and testbench
================================

Name: spi_master_tx

Overview:
- SPI master serializer that drives the CS/SCK/MOSI/spi_done lines consumed by the OLEDrgb SPI receiver stage. It is the stage directly upstream of that receiver.
- Accepts parallel words over a valid/ready handshake from the AXI/controller side.
- Shifts each word out MSB-first with a divided SCK, framed by CS.
- Pulses spi_done when a frame closes.

Parameters:
DATA_WIDTH, 8, bits per word; legal range 2..15, since the receiver's 4-bit bit counter limits it to 15.
CLK_DIV, 2, clk_i cycles per SCK half-period; minimum 1.

Ports:
clk_i  input  1  system clock; all logic on its rising edge.
rst_i  input  1  synchronous reset, active-high.
data_i  input  DATA_WIDTH  word to transmit.
valid_i  input  1  data_i is valid.
ready_o  output  1  block can accept a word; transfer occurs when valid_i && ready_o.
CS  output  1  slave select, active-low.
SCK  output  1  SPI clock; CPOL=0, idles low.
MOSI  output  1  serial data, MSB first.
spi_done  output  1  one-cycle pulse at frame end.
busy  output  1  high whenever state != IDLE.

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is synchronous and active-high.
- Reset values: CS=1, SCK=0, MOSI=0, spi_done=0, busy=0, ready_o=1, state=IDLE, all counters 0.
- All outputs are registered. There are no combinational paths from the inputs to the outputs.
- Slave timing: the slave samples MOSI on the SCK falling edge.
  - MOSI changes only in the cycle after a falling edge, or on CS assertion.
  - MOSI is therefore stable through the whole high phase and at the fall.
- States: IDLE -> SETUP -> SHIFT -> HOLD -> DONE -> IDLE.
- IDLE:
  - ready_o=1, CS=1, SCK=0.
  - On valid_i, latch data_i into the shift register and go to SETUP.
  - ready_o drops in the next cycle.
- SETUP (CLK_DIV cycles): CS=0, MOSI=data[MSB], SCK=0.
- SHIFT:
  - Each bit is CLK_DIV cycles of SCK high, then CLK_DIV cycles of SCK low.
  - After each low phase the shift register moves left and MOSI takes the next bit.
  - The bit counter runs 0..DATA_WIDTH-1.
  - After the low phase of bit index DATA_WIDTH-1, go to HOLD.
  - Exactly DATA_WIDTH falling edges occur per word.
- HOLD (CLK_DIV cycles): CS=0, SCK=0, MOSI holds the LSB.
- DONE (1 cycle): CS=1, spi_done=1, busy=1, ready_o=0. Then go to IDLE.
- Latency: the handshake in cycle 0 puts spi_done at cycle 2 + 2·CLK_DIV·(DATA_WIDTH+1) - 1. With the defaults that is cycle 37, and ready_o=1 again at cycle 38.
- The CLK_DIV counter is $clog2(CLK_DIV+1) bits wide and the bit counter is 4 bits. Both wrap only under explicit reload, never by overflow.
- valid_i and data_i are ignored while ready_o=0; data_i changes mid-frame have no effect.
- rst_i mid-frame: the next cycle shows the reset values. No spi_done is emitted for the aborted frame, and the partial word is lost.
- rst_i and valid_i together: reset wins and nothing is accepted.

Optional Feature:
- Macro: SPI_BURST_EN.
- Defined:
  - ready_o is also asserted during the final cycle of the last bit's low phase.
  - If valid_i is high in that cycle, the new word is loaded. SHIFT restarts at bit 0 with MOSI=new MSB in the next cycle, and CS stays low.
  - HOLD, DONE and SETUP are skipped between words.
  - spi_done pulses only once, when the burst ends (valid_i low at that cycle).
- Undefined:
  - ready_o is high only in IDLE.
  - Every word is a separate CS frame with its own spi_done pulse, and CS is high for at least 2 cycles (DONE plus IDLE) between frames.

Test Plan:
- Reset: hold rst_i 3 cycles during a transfer -> CS=1, SCK=0, MOSI=0, busy=0, ready_o=1 the cycle after release, with no spi_done pulse.
- Single word 0xA5, defaults -> CS low for cycles 1..36; 8 SCK falling edges with MOSI at the falls = 1,0,1,0,0,1,0,1; spi_done=1 only at cycle 37; ready_o=1 at cycle 38. A behavioural model of the receiver reports data_o=0xA5, done=1.
- Word 0xFF then 0x00 back-to-back, burst disabled -> two CS frames separated by >=2 cycles of CS=1; spi_done pulses twice; receiver outputs 0xFF then 0x00.
- SPI_BURST_EN defined, 0x3C and 0xC3 with valid_i held -> CS continuously low, 16 falling edges, single spi_done pulse; receiver done pulses twice with 0x3C then 0xC3.
- CLK_DIV=1, DATA_WIDTH=12, word 0x9A6 -> SCK period of 2 cycles, 12 falling edges, correct bit order, spi_done at cycle 27.
- data_i changed and valid_i toggled during SHIFT -> transmitted word unchanged and no extra frame started.

Source files
------------

// File: rtl/spi_master_tx.sv
// SPI master serializer (CPOL=0, MSB first, CS-framed) feeding the OLEDrgb SPI receiver.
// Optional macro SPI_BURST_EN: back-to-back words share one CS frame and one spi_done pulse.
module spi_master_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic                  CS,
  output logic                  SCK,
  output logic                  MOSI,
  output logic                  spi_done,
  output logic                  busy
);
  localparam int               DIV_W    = $clog2(CLK_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [3:0]       BIT_LAST = 4'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

  state_t                state_q, state_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [3:0]            bit_q, bit_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic                  sck_d, mosi_d, ready_d;
  logic                  div_end, last_bit, take;

  assign div_end  = (div_q == DIV_LAST);
  assign last_bit = (bit_q == BIT_LAST);
  assign take     = valid_i && ready_o;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    sck_d   = 1'b0;
    mosi_d  = MOSI;
    case (state_q)
      IDLE: if (take) begin
        state_d = SETUP;
        div_d   = '0;
        sh_d    = data_i;
        mosi_d  = data_i[DATA_WIDTH-1];
      end
      SETUP: if (div_end) begin
        state_d = SHIFT;
        div_d   = '0;
        bit_d   = '0;
        sck_d   = 1'b1;
      end else begin
        div_d = div_q + 1'b1;
      end
      SHIFT: begin
        // SCK register doubles as the high/low phase flag; MOSI moves only after a low phase
        if (!div_end) begin
          div_d = div_q + 1'b1;
          sck_d = SCK;
        end else if (SCK) begin
          div_d = '0;
        end else if (!last_bit) begin
          div_d  = '0;
          bit_d  = bit_q + 4'd1;
          sh_d   = sh_q << 1;
          mosi_d = sh_q[DATA_WIDTH-2];
          sck_d  = 1'b1;
        end
`ifdef SPI_BURST_EN
        else if (take) begin
          div_d  = '0;
          bit_d  = '0;
          sh_d   = data_i;
          mosi_d = data_i[DATA_WIDTH-1];
          sck_d  = 1'b1;
        end
`endif
        else begin
          state_d = HOLD;
          div_d   = '0;
        end
      end
      HOLD: if (div_end) begin
        state_d = DONE;
        div_d   = '0;
      end else begin
        div_d = div_q + 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
`ifdef SPI_BURST_EN
    // open the handshake for the final cycle of the last bit's low phase
    if (state_d == SHIFT && !sck_d && bit_d == BIT_LAST && div_d == DIV_LAST)
      ready_d = 1'b1;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      sh_q     <= '0;
      CS       <= 1'b1;
      SCK      <= 1'b0;
      MOSI     <= 1'b0;
      spi_done <= 1'b0;
      busy     <= 1'b0;
      ready_o  <= 1'b1;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      CS       <= !(state_d inside {SETUP, SHIFT, HOLD});
      SCK      <= sck_d;
      MOSI     <= mosi_d;
      spi_done <= (state_d == DONE);
      busy     <= (state_d != IDLE);
      ready_o  <= ready_d;
    end
  end
endmodule

// File: tb/tb_spi_master_tx.sv
// Bench for spi_master_tx: a default instance and a CLK_DIV=1/DATA_WIDTH=12 instance, both watched
// by a behavioural receiver that samples MOSI on SCK falling edges while CS is low.
module tb_spi_master_tx;
  localparam int A_DW = 8, A_CD = 2, B_DW = 12, B_CD = 1;
  // handshake cycle to spi_done cycle for an isolated word
  localparam int A_LAT = 2 + 2 * A_CD * (A_DW + 1) - 1;
  localparam int B_LAT = 2 + 2 * B_CD * (B_DW + 1) - 1;

  logic clk = 1'b0, rst = 1'b1;
  logic [A_DW-1:0] a_data = '0;
  logic [B_DW-1:0] b_data = '0;
  logic a_valid = 1'b0, b_valid = 1'b0;
  logic a_ready, a_cs, a_sck, a_mosi, a_done, a_busy;
  logic b_ready, b_cs, b_sck, b_mosi, b_done, b_busy;
  int cyc = 0;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_master_tx #(.DATA_WIDTH(A_DW), .CLK_DIV(A_CD)) u_a (
    .clk_i(clk), .rst_i(rst), .data_i(a_data), .valid_i(a_valid), .ready_o(a_ready),
    .CS(a_cs), .SCK(a_sck), .MOSI(a_mosi), .spi_done(a_done), .busy(a_busy));

  spi_master_tx #(.DATA_WIDTH(B_DW), .CLK_DIV(B_CD)) u_b (
    .clk_i(clk), .rst_i(rst), .data_i(b_data), .valid_i(b_valid), .ready_o(b_ready),
    .CS(b_cs), .SCK(b_sck), .MOSI(b_mosi), .spi_done(b_done), .busy(b_busy));

  // receiver / line monitor, index 0 = u_a, 1 = u_b
  int          fall_cyc[2][256];
  int          nfall[2] = '{0, 0};
  int          done_at[2][64];
  int          ndone[2] = '{0, 0};
  int          fr_start[2][64];
  int          fr_end[2][64];
  int          nfr[2] = '{0, 0};
  logic [15:0] rx_w[2][64];
  int          nrx[2] = '{0, 0};
  int          viol[2] = '{0, 0};
  int          rx_n[2] = '{0, 0};
  logic [15:0] rx_sh[2] = '{16'h0, 16'h0};
  logic        cs_q[2] = '{1'b1, 1'b1};
  logic        sck_q[2] = '{1'b0, 1'b0};
  logic        mosi_q[2] = '{1'b0, 1'b0};

  always @(negedge clk) begin
    logic cs_v, sck_v, mosi_v, dn_v;
    int   dw;
    for (int d = 0; d < 2; d++) begin
      cs_v   = (d == 0) ? a_cs   : b_cs;
      sck_v  = (d == 0) ? a_sck  : b_sck;
      mosi_v = (d == 0) ? a_mosi : b_mosi;
      dn_v   = (d == 0) ? a_done : b_done;
      dw     = (d == 0) ? A_DW   : B_DW;
      if (cs_v === 1'b0) begin
        if (cs_q[d] === 1'b1) begin
          if (nfr[d] < 64) fr_start[d][nfr[d]] = cyc;
          nfr[d]++;
        end
        if (nfr[d] > 0 && nfr[d] <= 64) fr_end[d][nfr[d]-1] = cyc;
        if (sck_q[d] && !sck_v) begin
          if (mosi_v !== mosi_q[d]) viol[d]++;
          if (nfall[d] < 256) fall_cyc[d][nfall[d]] = cyc;
          nfall[d]++;
          rx_sh[d] = {rx_sh[d][14:0], mosi_q[d]};
          rx_n[d]++;
          if (rx_n[d] == dw) begin
            if (nrx[d] < 64) rx_w[d][nrx[d]] = rx_sh[d] & 16'((1 << dw) - 1);
            nrx[d]++;
            rx_n[d] = 0;
          end
        end else if (sck_q[d] && sck_v && mosi_v !== mosi_q[d]) begin
          viol[d]++;
        end
      end else begin
        rx_n[d] = 0;
        if (sck_v !== 1'b0) viol[d]++;
      end
      if (dn_v === 1'b1) begin
        if (ndone[d] < 64) done_at[d][ndone[d]] = cyc;
        ndone[d]++;
      end
      cs_q[d]   = cs_v;
      sck_q[d]  = sck_v;
      mosi_q[d] = mosi_v;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic accept_a(output int c);
    c = -1;
    for (int i = 0; i < 200 && c < 0; i++) begin
      @(negedge clk);
      if (a_ready) c = cyc;
    end
    tick(1);
    n_chk++;
    if (c < 0) begin n_fail++; $display("FAIL accept_a: no handshake within 200 cycles"); end
  endtask

  task automatic accept_b(output int c);
    c = -1;
    for (int i = 0; i < 200 && c < 0; i++) begin
      @(negedge clk);
      if (b_ready) c = cyc;
    end
    tick(1);
    n_chk++;
    if (c < 0) begin n_fail++; $display("FAIL accept_b: no handshake within 200 cycles"); end
  endtask

  task automatic send_a(input logic [A_DW-1:0] w, output int c);
    a_data = w; a_valid = 1'b1;
    accept_a(c);
    a_valid = 1'b0;
  endtask

  task automatic send_b(input logic [B_DW-1:0] w, output int c);
    b_data = w; b_valid = 1'b1;
    accept_b(c);
    b_valid = 1'b0;
  endtask

  task automatic wait_idle_a();
    int i = 0;
    do begin @(negedge clk); i++; end while (!(a_cs && a_ready && !a_busy) && i < 300);
    n_chk++;
    if (i >= 300) begin n_fail++; $display("FAIL idle_a: still busy after 300 cycles"); end
    tick(1);
  endtask

  task automatic wait_idle_b();
    int i = 0;
    do begin @(negedge clk); i++; end while (!(b_cs && b_ready && !b_busy) && i < 300);
    n_chk++;
    if (i >= 300) begin n_fail++; $display("FAIL idle_b: still busy after 300 cycles"); end
    tick(1);
  endtask

  task automatic test_reset();
    int c0, nd, nr, nf;
    rst = 1'b1; tick(3);
    n_chk++;
    if ({a_cs, a_sck, a_mosi, a_done, a_busy, a_ready} !== 6'b100001) begin
      n_fail++; $display("FAIL reset_a: got %b want 100001", {a_cs, a_sck, a_mosi, a_done, a_busy, a_ready});
    end
    n_chk++;
    if ({b_cs, b_sck, b_mosi, b_done, b_busy, b_ready} !== 6'b100001) begin
      n_fail++; $display("FAIL reset_b: got %b want 100001", {b_cs, b_sck, b_mosi, b_done, b_busy, b_ready});
    end
    rst = 1'b0; tick(2);
    send_a(8'h5A, c0);
    tick(12);
    nd = ndone[0]; nr = nrx[0];
    n_chk++;
    if (a_cs !== 1'b0 || a_busy !== 1'b1) begin
      n_fail++; $display("FAIL midframe_active: cs=%b busy=%b want 0 1", a_cs, a_busy);
    end
    rst = 1'b1; a_valid = 1'b1; a_data = 8'hFF;
    tick(1);
    n_chk++;
    if ({a_cs, a_sck, a_mosi, a_done, a_busy, a_ready} !== 6'b100001) begin
      n_fail++; $display("FAIL reset_midframe: got %b want 100001", {a_cs, a_sck, a_mosi, a_done, a_busy, a_ready});
    end
    tick(2);
    rst = 1'b0; a_valid = 1'b0;
    nf = nfr[0];
    tick(1);
    n_chk++;
    if ({a_cs, a_sck, a_mosi, a_done, a_busy, a_ready} !== 6'b100001) begin
      n_fail++; $display("FAIL reset_release: got %b want 100001", {a_cs, a_sck, a_mosi, a_done, a_busy, a_ready});
    end
    tick(50);
    n_chk++;
    if (ndone[0] !== nd) begin n_fail++; $display("FAIL reset_no_done: got %0d pulses want %0d", ndone[0], nd); end
    n_chk++;
    if (nrx[0] !== nr) begin n_fail++; $display("FAIL reset_partial_lost: got %0d words want %0d", nrx[0], nr); end
    n_chk++;
    if (nfr[0] !== nf || a_busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_wins_valid: frames %0d busy %b want %0d 0", nfr[0], a_busy, nf);
    end
  endtask

  task automatic test_single();
    int c0, f0, d0, r0, fl0, v0;
    f0 = nfr[0]; d0 = ndone[0]; r0 = nrx[0]; fl0 = nfall[0]; v0 = viol[0];
    send_a(8'hA5, c0);
    tick(A_LAT - 1);
    n_chk++;
    if (a_done !== 1'b1 || a_ready !== 1'b0) begin
      n_fail++; $display("FAIL single_done_cycle: done=%b ready=%b want 1 0", a_done, a_ready);
    end
    tick(1);
    n_chk++;
    if (a_ready !== 1'b1 || a_done !== 1'b0) begin
      n_fail++; $display("FAIL single_ready_back: ready=%b done=%b want 1 0", a_ready, a_done);
    end
    wait_idle_a();
    n_chk++;
    if (nfr[0] - f0 !== 1 || fr_start[0][f0] !== c0 + 1 || fr_end[0][f0] !== c0 + A_LAT - 1) begin
      n_fail++; $display("FAIL single_cs_window: frames %0d start %0d end %0d want 1 %0d %0d",
                         nfr[0] - f0, fr_start[0][f0], fr_end[0][f0], c0 + 1, c0 + A_LAT - 1);
    end
    n_chk++;
    if (nfall[0] - fl0 !== A_DW) begin n_fail++; $display("FAIL single_falls: got %0d want %0d", nfall[0] - fl0, A_DW); end
    n_chk++;
    if (nrx[0] - r0 !== 1 || rx_w[0][r0] !== 16'h00A5) begin
      n_fail++; $display("FAIL single_rx: got %0d words %h want 1 00a5", nrx[0] - r0, rx_w[0][r0]);
    end
    n_chk++;
    if (ndone[0] - d0 !== 1 || done_at[0][d0] !== c0 + A_LAT) begin
      n_fail++; $display("FAIL single_done: got %0d pulses at %0d want 1 at %0d", ndone[0] - d0, done_at[0][d0], c0 + A_LAT);
    end
    n_chk++;
    if (viol[0] !== v0) begin n_fail++; $display("FAIL single_line_timing: got %0d violations want 0", viol[0] - v0); end
  endtask

`ifdef SPI_BURST_EN
  task automatic test_burst();
    int c0, c1, f0, d0, r0, fl0, v0;
    f0 = nfr[0]; d0 = ndone[0]; r0 = nrx[0]; fl0 = nfall[0]; v0 = viol[0];
    a_data = 8'h3C; a_valid = 1'b1;
    accept_a(c0);
    a_data = 8'hC3;
    accept_a(c1);
    a_valid = 1'b0;
    wait_idle_a();
    n_chk++;
    if (c1 - c0 !== A_CD + 2 * A_CD * A_DW) begin
      n_fail++; $display("FAIL burst_accept_gap: got %0d want %0d", c1 - c0, A_CD + 2 * A_CD * A_DW);
    end
    n_chk++;
    if (nfr[0] - f0 !== 1) begin n_fail++; $display("FAIL burst_one_frame: got %0d frames want 1", nfr[0] - f0); end
    n_chk++;
    if (nfall[0] - fl0 !== 2 * A_DW) begin n_fail++; $display("FAIL burst_falls: got %0d want %0d", nfall[0] - fl0, 2 * A_DW); end
    n_chk++;
    if (ndone[0] - d0 !== 1 || done_at[0][d0] !== c0 + 2 * A_CD + 4 * A_CD * A_DW + 1) begin
      n_fail++; $display("FAIL burst_done: got %0d pulses at %0d want 1 at %0d",
                         ndone[0] - d0, done_at[0][d0], c0 + 2 * A_CD + 4 * A_CD * A_DW + 1);
    end
    n_chk++;
    if (nrx[0] - r0 !== 2 || rx_w[0][r0] !== 16'h003C || rx_w[0][r0+1] !== 16'h00C3) begin
      n_fail++; $display("FAIL burst_rx: got %0d words %h %h want 2 003c 00c3", nrx[0] - r0, rx_w[0][r0], rx_w[0][r0+1]);
    end
    n_chk++;
    if (viol[0] !== v0) begin n_fail++; $display("FAIL burst_line_timing: got %0d violations want 0", viol[0] - v0); end
  endtask
`else
  task automatic test_back_to_back();
    int c0, c1, f0, d0, r0, fl0, v0, gap;
    f0 = nfr[0]; d0 = ndone[0]; r0 = nrx[0]; fl0 = nfall[0]; v0 = viol[0];
    a_data = 8'hFF; a_valid = 1'b1;
    accept_a(c0);
    a_data = 8'h00;
    accept_a(c1);
    a_valid = 1'b0;
    wait_idle_a();
    n_chk++;
    if (c1 - c0 !== A_LAT + 1) begin n_fail++; $display("FAIL b2b_accept_gap: got %0d want %0d", c1 - c0, A_LAT + 1); end
    n_chk++;
    if (nfr[0] - f0 !== 2) begin n_fail++; $display("FAIL b2b_frames: got %0d want 2", nfr[0] - f0); end
    gap = fr_start[0][f0+1] - fr_end[0][f0] - 1;
    n_chk++;
    if (gap < 2) begin n_fail++; $display("FAIL b2b_cs_gap: got %0d cycles want >= 2", gap); end
    n_chk++;
    if (ndone[0] - d0 !== 2 || done_at[0][d0] !== c0 + A_LAT || done_at[0][d0+1] !== c1 + A_LAT) begin
      n_fail++; $display("FAIL b2b_done: got %0d pulses at %0d %0d want 2 at %0d %0d",
                         ndone[0] - d0, done_at[0][d0], done_at[0][d0+1], c0 + A_LAT, c1 + A_LAT);
    end
    n_chk++;
    if (nrx[0] - r0 !== 2 || rx_w[0][r0] !== 16'h00FF || rx_w[0][r0+1] !== 16'h0000) begin
      n_fail++; $display("FAIL b2b_rx: got %0d words %h %h want 2 00ff 0000", nrx[0] - r0, rx_w[0][r0], rx_w[0][r0+1]);
    end
    n_chk++;
    if (nfall[0] - fl0 !== 2 * A_DW || viol[0] !== v0) begin
      n_fail++; $display("FAIL b2b_lines: got %0d falls %0d violations want %0d 0", nfall[0] - fl0, viol[0] - v0, 2 * A_DW);
    end
  endtask
`endif

  task automatic test_clkdiv1();
    int c0, d0, r0, fl0, v0, bad;
    d0 = ndone[1]; r0 = nrx[1]; fl0 = nfall[1]; v0 = viol[1]; bad = 0;
    send_b(12'h9A6, c0);
    wait_idle_b();
    n_chk++;
    if (nfall[1] - fl0 !== B_DW) begin n_fail++; $display("FAIL div1_falls: got %0d want %0d", nfall[1] - fl0, B_DW); end
    for (int i = 1; i < B_DW; i++)
      if (fall_cyc[1][fl0+i] - fall_cyc[1][fl0+i-1] != 2 * B_CD) bad++;
    n_chk++;
    if (bad !== 0) begin n_fail++; $display("FAIL div1_sck_period: got %0d irregular periods want 0", bad); end
    n_chk++;
    if (nrx[1] - r0 !== 1 || rx_w[1][r0] !== 16'h09A6) begin
      n_fail++; $display("FAIL div1_rx: got %0d words %h want 1 09a6", nrx[1] - r0, rx_w[1][r0]);
    end
    n_chk++;
    if (ndone[1] - d0 !== 1 || done_at[1][d0] !== c0 + B_LAT) begin
      n_fail++; $display("FAIL div1_done: got %0d pulses at %0d want 1 at %0d", ndone[1] - d0, done_at[1][d0], c0 + B_LAT);
    end
    n_chk++;
    if (viol[1] !== v0) begin n_fail++; $display("FAIL div1_line_timing: got %0d violations want 0", viol[1] - v0); end
  endtask

  task automatic test_data_change();
    logic [A_DW-1:0] w;
    int c0, f0, d0, r0;
    f0 = nfr[0]; d0 = ndone[0]; r0 = nrx[0];
    w = 8'($urandom);
    send_a(w, c0);
    for (int i = 0; i < 16; i++) begin
      a_data = 8'($urandom); a_valid = 1'($urandom);
      tick(1);
    end
    a_valid = 1'b0;
    wait_idle_a();
    tick(5);
    n_chk++;
    if (nrx[0] - r0 !== 1 || rx_w[0][r0] !== {8'h00, w}) begin
      n_fail++; $display("FAIL midframe_data: got %0d words %h want 1 %h", nrx[0] - r0, rx_w[0][r0], w);
    end
    n_chk++;
    if (nfr[0] - f0 !== 1 || ndone[0] - d0 !== 1 || a_busy !== 1'b0) begin
      n_fail++; $display("FAIL midframe_no_extra: frames %0d dones %0d busy %b want 1 1 0", nfr[0] - f0, ndone[0] - d0, a_busy);
    end
    n_chk++;
    if (done_at[0][d0] !== c0 + A_LAT) begin
      n_fail++; $display("FAIL midframe_latency: got %0d want %0d", done_at[0][d0], c0 + A_LAT);
    end
  endtask

  task automatic test_random();
    logic [A_DW-1:0] wa;
    logic [B_DW-1:0] wb;
    int c0, d0, r0;
    for (int k = 0; k < 5; k++) begin
      d0 = ndone[0]; r0 = nrx[0];
      wa = 8'($urandom);
      tick($urandom_range(0, 3));
      send_a(wa, c0);
      wait_idle_a();
      n_chk++;
      if (rx_w[0][r0] !== {8'h00, wa} || done_at[0][d0] !== c0 + A_LAT) begin
        n_fail++; $display("FAIL random_a[%0d]: got %h at %0d want %h at %0d", k, rx_w[0][r0], done_at[0][d0], wa, c0 + A_LAT);
      end
    end
    for (int k = 0; k < 3; k++) begin
      d0 = ndone[1]; r0 = nrx[1];
      wb = 12'($urandom);
      tick($urandom_range(0, 3));
      send_b(wb, c0);
      wait_idle_b();
      n_chk++;
      if (rx_w[1][r0] !== {4'h0, wb} || done_at[1][d0] !== c0 + B_LAT) begin
        n_fail++; $display("FAIL random_b[%0d]: got %h at %0d want %h at %0d", k, rx_w[1][r0], done_at[1][d0], wb, c0 + B_LAT);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
`ifdef SPI_BURST_EN
    test_burst();
`else
    test_back_to_back();
`endif
    test_clkdiv1();
    test_data_change();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 20000 cycles");
    $fatal(1, "watchdog expired");
  end
endmodule
